// File: rtl/picosoc_min_pkg.sv
// picosoc_min_pkg: opcodes, instruction/program types, sequencer states and the default LED program
package picosoc_min_pkg;

    localparam int ROM_MAX = 64;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADDI = 4'd2,
        OP_OUT  = 4'd3,
        OP_JMP  = 4'd4,
        OP_DLY  = 4'd5,
        OP_XORI = 4'd6,
        OP_ROTL = 4'd7
    } op_e;

    // op stays a raw nibble so that 8-15 can exist in ROM and decode as NOP
    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] imm;
    } instr_t;

    typedef logic [ROM_MAX-1:0][15:0] prog_t;

    typedef enum logic {RUN, WAIT} state_e;

    // walking-LED loop; all-zero words are NOPs
    function automatic prog_t default_prog(logic [11:0] dly);
        prog_t p;
        p    = '0;
        p[0] = {OP_LDI, 12'd1};
        p[1] = {OP_OUT, 12'd0};
        p[2] = {OP_DLY, dly};
        p[3] = {OP_ROTL, 12'd0};
        p[4] = {OP_JMP, 12'd1};
        return p;
    endfunction

endpackage

// File: rtl/picosoc_min_rom.sv
// picosoc_min_rom: combinational ROM_DEPTH x 16 program lookup
//   addr_i  : word address
//   instr_o : decoded instruction word at addr_i
module picosoc_min_rom
    import picosoc_min_pkg::*;
#(
    parameter int    ROM_DEPTH = 16,
    parameter prog_t PROG      = default_prog(12'd1000)
) (
    input  logic [$clog2(ROM_DEPTH)-1:0] addr_i,
    output instr_t                       instr_o
);

    assign instr_o = instr_t'(PROG[addr_i]);

endmodule

// File: rtl/picosoc_min.sv
// picosoc_min: self-running accumulator micro-sequencer driving a registered LED output
//   clk    : system clock, rising edge
//   resetn : asynchronous reset, active-high despite the name
//   ledr   : LED drive, 1 = lit, flop output
// Optional build macro PICOSOC_HEARTBEAT_EN puts a free-running counter MSB on ledr[9].
module picosoc_min
    import picosoc_min_pkg::*;
#(
    parameter int    ROM_DEPTH = 16,
    parameter int    DLY_DEF   = 1000,
    parameter int    HB_BITS   = 10,
    parameter prog_t PROG      = default_prog(12'(DLY_DEF))
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] ledr
);

    localparam int AW = $clog2(ROM_DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [9:0]    acc_q, acc_d, led_q, led_d;
    logic [11:0]   cnt_q, cnt_d;
    state_e        st_q, st_d;
    instr_t        ins;

    picosoc_min_rom #(.ROM_DEPTH(ROM_DEPTH), .PROG(PROG)) u_rom (
        .addr_i  (pc_q),
        .instr_o (ins)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            pc_q  <= '0;
            acc_q <= '0;
            led_q <= '0;
            cnt_q <= '0;
            st_q  <= RUN;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            led_q <= led_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    // DLY imm>1 issues one cycle in RUN then imm-1 cycles in WAIT, counting imm-2 down to 0
    always_comb begin
        pc_d  = pc_q + AW'(1);
        acc_d = acc_q;
        led_d = led_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        if (st_q == WAIT) begin
            st_d  = (cnt_q == '0) ? RUN : WAIT;
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 12'd1;
            pc_d  = (cnt_q == '0) ? pc_q + AW'(1) : pc_q;
        end else begin
            case (ins.op)
                OP_LDI:  acc_d = ins.imm[9:0];
                OP_ADDI: acc_d = acc_q + ins.imm[9:0];
                OP_OUT:  led_d = acc_q;
                OP_JMP:  pc_d  = ins.imm[AW-1:0];
                OP_DLY: if (ins.imm > 12'd1) begin
                    st_d  = WAIT;
                    cnt_d = ins.imm - 12'd2;
                    pc_d  = pc_q;
                end
                OP_XORI: acc_d = acc_q ^ ins.imm[9:0];
                OP_ROTL: acc_d = {acc_q[8:0], acc_q[9]};
                default: ;
            endcase
        end
    end

`ifdef PICOSOC_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_q;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) hb_q <= '0;
        else        hb_q <= hb_q + HB_BITS'(1);
    end

    assign ledr = {hb_q[HB_BITS-1], led_q[8:0]};
`else
    assign ledr = led_q;
`endif

endmodule

// File: tb/tb_picosoc_min.sv
// tb_picosoc_min: directed checks of the LED sequencer with slow, fast and custom programs
module tb_picosoc_min;
    import picosoc_min_pkg::*;

`ifdef PICOSOC_HEARTBEAT_EN
    localparam logic [9:0] LM = 10'h1FF;
`else
    localparam logic [9:0] LM = 10'h3FF;
`endif

    // LDI 3FF; OUT; op F (NOP); ADDI 1; OUT; XORI 155; OUT; JMP 0x17 (-> 7)
    function automatic prog_t mk_prog();
        prog_t p;
        p    = '0;
        p[0] = 16'h13FF;
        p[1] = 16'h3000;
        p[2] = 16'hF123;
        p[3] = 16'h2001;
        p[4] = 16'h3000;
        p[5] = 16'h6155;
        p[6] = 16'h3000;
        p[7] = 16'h4017;
        return p;
    endfunction

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [9:0] led0, led1, led2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    picosoc_min #(.DLY_DEF(1000)) u0 (.clk(clk), .resetn(resetn), .ledr(led0));
    picosoc_min #(.DLY_DEF(4))    u1 (.clk(clk), .resetn(resetn), .ledr(led1));
    picosoc_min #(.PROG(mk_prog())) u2 (.clk(clk), .resetn(resetn), .ledr(led2));

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if ((got & LM) !== (exp & LM)) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(5);
        check("rst_hold0", led0, 10'h000);
        check("rst_hold2", led2, 10'h000);
        #2 resetn = 1'b0;
        tick(1);
        check("edge1", led0, 10'h000);
        tick(1);
        check("edge2_u0", led0, 10'h001);
        check("edge2_u1", led1, 10'h001);
        check("edge2_u2", led2, 10'h3FF);
        tick(2);
        check("nop_opF", led2, 10'h3FF);
        tick(1);
        check("addi_wrap", led2, 10'h000);
        tick(2);
        check("xori", led2, 10'h155);
        tick(1);
        check("u1_hold8", led1, 10'h001);
        tick(1);
        check("u1_step1", led1, 10'h002);
        for (int k = 2; k <= 10; k++) begin
            tick(7);
            check($sformatf("u1_step%0d", k), led1, (k == 10) ? 10'h001 : 10'(1 << k));
        end
        check("jmp_mod", led2, 10'h155);
        tick(932);
        check("u0_hold1004", led0, 10'h001);
        tick(1);
        check("u0_1005", led0, 10'h002);
        tick(1003);
        check("u0_2008", led0, 10'h004);
        tick(1003);
        check("u0_3011", led0, 10'h008);
        tick(1003);
        check("u0_4014", led0, 10'h010);
        tick(500);
        #2 resetn = 1'b1;
        #1;
        check("async_rst_u0", led0, 10'h000);
        check("async_rst_u2", led2, 10'h000);
        tick(5);
        check("rst_hold_u0", led0, 10'h000);
        #2 resetn = 1'b0;
        tick(1);
        check("restart_e1", led0, 10'h000);
        tick(1);
        check("restart_e2", led0, 10'h001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
